// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, LSB first, one full-subtractor
// cell plus a borrow flop; parallel result presented with a done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             diff_bit,
  output logic             diff_bit_valid
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic w_x;
  logic w_y;
  logic w_d;
  logic w_br_nxt;
  logic w_run;
  logic w_last;

  assign w_x      = r_sa[0];
  assign w_y      = r_sb[0];
  assign w_d      = w_x ^ w_y ^ r_br;
  assign w_br_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_diff   <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_sa  <= a;
        r_sb  <= b;
        r_br  <= 1'b0;
        r_cnt <= '0;
      end else if (w_run) begin
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_sr  <= {w_d, r_sr[WIDTH-1:1]};
        r_br  <= w_br_nxt;
        r_cnt <= r_cnt + 1'b1;
        // result only becomes visible once every bit is in
        if (w_last) begin
          r_diff   <= {w_d, r_sr[WIDTH-1:1]};
          r_borrow <= w_br_nxt;
        end
      end
    end
  end

  assign busy           = w_run;
  assign done           = (r_state == S_DONE);
  assign diff           = r_diff;
  assign borrow         = r_borrow;
  assign diff_bit       = w_run & w_d;
  assign diff_bit_valid = w_run;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected
// results, a negedge monitor checks done/diff/borrow/serial stream.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         diff_bit;
  logic         diff_bit_valid;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .a              (a),
    .b              (b),
    .busy           (busy),
    .done           (done),
    .diff           (diff),
    .borrow         (borrow),
    .diff_bit       (diff_bit),
    .diff_bit_valid (diff_bit_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    int           cyc;
  } exp_t;

  exp_t   q[$];
  logic   bits[$];
  int     n_vec     = 0;
  int     n_err     = 0;
  int     cyc       = 0;
  int     next_free = 0;
  logic   m_eb;
  exp_t   m_e;
  logic [W-1:0] m_ser;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Model: start is taken only when the block is free; result is
  // plain modular subtraction, due WIDTH+1 cycles after acceptance.
  task automatic drive(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic st);
    exp_t e;
    a     = aa;
    b     = bb;
    start = st;
    if (st && cyc >= next_free) begin
      e.d   = W'(int'(aa) - int'(bb));
      e.br  = (aa < bb);
      e.cyc = cyc + W + 1;
      q.push_back(e);
      next_free = cyc + W + 2;
    end
  endtask

  task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    drive(aa, bb, 1'b1);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    repeat (11) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_done"},   32'(done), 32'd0);
    chk({tag, "_diff"},   32'(diff), 32'd0);
    chk({tag, "_borrow"}, 32'(borrow), 32'd0);
    chk({tag, "_bit"},    32'(diff_bit), 32'd0);
    chk({tag, "_bitv"},   32'(diff_bit_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      bits.delete();
    end else begin
      m_eb = (q.size() > 0) && (cyc > q[0].cyc - W - 1) && (cyc < q[0].cyc);
      chk("busy", 32'(busy), 32'(m_eb));
      chk("bit_valid", 32'(diff_bit_valid), 32'(m_eb));
      if (diff_bit_valid) bits.push_back(diff_bit);
      else chk("bit_idle", 32'(diff_bit), 32'd0);
      if (q.size() > 0 && cyc > q[0].cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL no_done: got none expected done at cycle %0d",
                 q[0].cyc);
        void'(q.pop_front());
        bits.delete();
      end
      if (done) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_done: got done expected none (cycle %0d)",
                   cyc);
        end else begin
          m_e = q.pop_front();
          chk("latency", 32'(cyc), 32'(m_e.cyc));
          chk("diff", 32'(diff), 32'(m_e.d));
          chk("borrow", 32'(borrow), 32'(m_e.br));
          chk("serial_len", 32'(bits.size()), 32'(W));
          m_ser = '0;
          foreach (bits[i]) if (i < W) m_ser[i] = bits[i];
          chk("serial", 32'(m_ser), 32'(m_e.d));
        end
        bits.delete();
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    op(8'd100, 8'd37);
    op(8'd5,   8'd9);
    op(8'd0,   8'd1);
    op(8'd255, 8'd255);
    op(8'd0,   8'd0);
    op(8'd255, 8'd0);

    // re-trigger in cycle 4 and in the DONE cycle must be ignored
    @(negedge clk);
    drive(8'd100, 8'd37, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    drive(8'd1, 8'd2, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    drive(8'd1, 8'd2, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // start held high: three operations, done every W+2 cycles
    repeat (21) begin
      @(negedge clk);
      drive(W'($urandom), W'($urandom), 1'b1);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // reset in cycle 5 of an operation aborts it
    @(negedge clk);
    drive(8'd200, 8'd50, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    next_free = 0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    op(8'd10, 8'd3);

    repeat (300) begin
      @(negedge clk);
      drive(W'($urandom), W'($urandom), ($urandom % 3) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
